// File: rtl/pseudo_spi_rx_intf.sv
// Pseudo-SPI receive interface: clocks in LSB-first serial words with two-phase scan clocks and writes them to SRAM, descending from ADDR_BGN.
// Optional macro PSEUDO_SPI_RX_FREQ_DIV_EN adds FREQ_DIV to stretch each scan-clock phase to FREQ_DIV+1 cycles.
module pseudo_spi_rx_intf #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 9,
    parameter int RESERVED_DATA_LEN = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         BGN,
    input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
    input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
    input  logic [7:0]                   FREQ_DIV,
`endif
    input  logic                         SPI_SI,
    output logic                         SCLK1,
    output logic                         SCLK2,
    output logic                         LAT,
    output logic                         CEN,
    output logic [MEMORY_ADDR_WIDTH-1:0] A,
    output logic                         D_WE,
    output logic [MEMORY_DATA_WIDTH-1:0] PO,
    output logic                         SPI_IS_DONE,
    output logic [2:0]                   o_dbg_state
);
    localparam int DW = MEMORY_DATA_WIDTH;
    localparam int AW = MEMORY_ADDR_WIDTH;
    localparam int LW = RESERVED_DATA_LEN;
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PH1   = 3'd1,
        S_PH2   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_addr;
    logic [LW-1:0]   r_cnt;
    logic [DW-1:0]   r_shift;
    logic [BW-1:0]   r_bit_cnt;
    logic [7:0]      r_div_cnt;
    logic [AW-1:0]   r_a;
    logic [DW-1:0]   r_po;
    logic [7:0]      w_div;
    logic            w_phase_end;
    logic            w_last_bit;
    logic [DW-1:0]   w_shift_in;

`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
    logic [7:0] r_div;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_div <= 8'd0;
        else if (r_state == S_IDLE && BGN)
            r_div <= FREQ_DIV;
    end
    assign w_div = r_div;
`else
    assign w_div = 8'd0;
`endif

    assign w_phase_end = (r_div_cnt == w_div);
    assign w_last_bit  = (r_bit_cnt == BW'(DW - 1));
    assign w_shift_in  = {SPI_SI, r_shift[DW-1:1]};
    assign A           = r_a;
    assign PO          = r_po;
    assign o_dbg_state = r_state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        SCLK1       = 1'b0;
        SCLK2       = 1'b0;
        LAT         = 1'b0;
        CEN         = 1'b1;
        D_WE        = 1'b0;
        SPI_IS_DONE = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (BGN)
                    w_next = (DATA_LEN == '0) ? S_DONE : S_PH1;
            end
            S_PH1: begin
                SCLK1 = 1'b1;
                if (w_phase_end)
                    w_next = S_PH2;
            end
            S_PH2: begin
                SCLK2 = 1'b1;
                if (w_phase_end)
                    w_next = w_last_bit ? S_WRITE : S_PH1;
            end
            S_WRITE: begin
                LAT    = 1'b1;
                CEN    = 1'b0;
                D_WE   = 1'b1;
                w_next = (r_cnt > LW'(1)) ? S_PH1 : S_DONE;
            end
            S_DONE: begin
                SPI_IS_DONE = 1'b1;
                if (!BGN)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The SRAM-facing A/PO are loaded on the last sample so they are stable for the whole WRITE cycle and hold afterwards.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_addr    <= '0;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= 8'd0;
            r_a       <= '0;
            r_po      <= '0;
        end else begin
            if (r_state == S_PH1 || r_state == S_PH2)
                r_div_cnt <= w_phase_end ? 8'd0 : r_div_cnt + 8'd1;
            else
                r_div_cnt <= 8'd0;

            case (r_state)
                S_IDLE: begin
                    if (BGN) begin
                        r_addr    <= ADDR_BGN;
                        r_cnt     <= DATA_LEN;
                        r_bit_cnt <= '0;
                    end
                end
                S_PH2: begin
                    if (w_phase_end) begin
                        r_shift <= w_shift_in;
                        if (w_last_bit) begin
                            r_bit_cnt <= '0;
                            r_a       <= r_addr;
                            r_po      <= w_shift_in;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    r_addr <= r_addr - AW'(1);
                    r_cnt  <= r_cnt - LW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pseudo_spi_rx_intf.sv
// Bench for pseudo_spi_rx_intf: a driver serializes words at the cycles implied by the timing rules, a monitor checks SRAM writes against a queue.
// Build with PSEUDO_SPI_RX_FREQ_DIV_EN to also exercise the divided scan clock.
module tb_pseudo_spi_rx_intf;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int EW = 32 + AW + DW;

  logic          CLK = 1'b0;
  logic          RST;
  logic          BGN;
  logic [AW-1:0] ADDR_BGN;
  logic [7:0]    DATA_LEN;
`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
  logic [7:0]    FREQ_DIV;
`endif
  logic          SPI_SI;
  logic          SCLK1, SCLK2, LAT, CEN, D_WE, SPI_IS_DONE;
  logic [AW-1:0] A;
  logic [DW-1:0] PO;
  logic [2:0]    dbg_state;

  pseudo_spi_rx_intf dut (
    .CLK(CLK), .RST(RST), .BGN(BGN), .ADDR_BGN(ADDR_BGN), .DATA_LEN(DATA_LEN),
`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
    .FREQ_DIV(FREQ_DIV),
`endif
    .SPI_SI(SPI_SI), .SCLK1(SCLK1), .SCLK2(SCLK2), .LAT(LAT), .CEN(CEN),
    .A(A), .D_WE(D_WE), .PO(PO), .SPI_IS_DONE(SPI_IS_DONE), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;
  int unsigned g_edge = 0;
  always @(posedge CLK) g_edge <= g_edge + 1;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] exp_mem[512];
  logic [DW-1:0] act_mem[512];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // monitor: invariants every cycle, SRAM writes popped against the expected queue
  always @(negedge CLK) begin
    if (!RST) begin
      chk("sclk_rule", {63'd0, (SCLK1 && SCLK2) || ((SCLK1 || SCLK2) && (!CEN || SPI_IS_DONE))}, 64'd0);
      if (!CEN) begin
        chk("write_strobes", {62'd0, D_WE, LAT}, 64'd3);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {32'd0, g_edge}, 64'hFFFF_FFFF);
        end else begin
          chk("write_cycle_addr_data", {15'd0, g_edge, A, PO}, {15'd0, exp_q.pop_front()});
        end
        act_mem[A] = PO;
      end
    end
  end

  // driver: one transfer, inputs driven per cycle, SPI_IS_DONE timing checked by the bench
  task automatic run_xfer(input logic [AW-1:0] addr, input int len, input int div,
                          input logic [DW-1:0] words[$]);
    int ph;
    int wlen;
    int total;
    int unsigned t0;
    logic [AW-1:0] a;
    ph = div + 1;
    wlen = 16 * ph + 1;
    total = len * wlen + 1;
    @(negedge CLK);
    ADDR_BGN = addr;
    DATA_LEN = 8'(len);
`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
    FREQ_DIV = 8'(div);
`endif
    BGN = 1'b1;
    SPI_SI = 1'($urandom);
    t0 = g_edge;
    for (int k = 0; k < len; k++) begin
      a = addr - AW'(k);
      exp_q.push_back({32'(t0 + 32'((k + 1) * wlen)), a, words[k]});
      exp_mem[a] = words[k];
    end
    for (int n = 1; n <= total; n++) begin
      int q;
      int k;
      @(negedge CLK);
      ADDR_BGN = AW'($urandom);
      DATA_LEN = 8'($urandom);
`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
      FREQ_DIV = 8'($urandom);
`endif
      k = (n - 1) / wlen;
      q = (n - 1) % wlen + 1;
      if (n < total && q <= 16 * ph && (q % (2 * ph)) == 0)
        SPI_SI = words[k][q / (2 * ph) - 1];
      else
        SPI_SI = 1'($urandom);
      #1;
      chk("done_timing", {63'd0, SPI_IS_DONE}, {63'd0, n == total});
    end
    @(negedge CLK);
    #1 chk("done_held", {63'd0, SPI_IS_DONE}, 64'd1);
    BGN = 1'b0;
    @(negedge CLK);
    #1 chk("done_clear", {63'd0, SPI_IS_DONE}, 64'd0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk(nm, {44'd0, SCLK1, SCLK2, LAT, CEN, D_WE, SPI_IS_DONE, A, PO}, {44'd0, 6'b000100, 9'd0, 8'd0});
  endtask

  // reset asserted in cycle 9 of word 1: no write, outputs back at reset values immediately
  task automatic reset_mid_word();
    @(negedge CLK);
    ADDR_BGN = AW'($urandom);
    DATA_LEN = 8'd2;
`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
    FREQ_DIV = 8'd0;
`endif
    BGN = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge CLK);
      SPI_SI = 1'($urandom);
    end
    RST = 1'b1;
    #1 chk_reset_outputs("reset_mid_word");
    BGN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  function automatic void rand_words(output logic [DW-1:0] w[$], input int len);
    w = {};
    for (int i = 0; i < len; i++) w.push_back(DW'($urandom));
  endfunction

  initial begin
    logic [DW-1:0] w[$];
    for (int i = 0; i < 512; i++) begin
      exp_mem[i] = '0;
      act_mem[i] = '0;
    end
    RST = 1'b1;
    BGN = 1'b0;
    SPI_SI = 1'b0;
    ADDR_BGN = '0;
    DATA_LEN = '0;
`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
    FREQ_DIV = '0;
`endif
    repeat (2) @(negedge CLK);
    #1 chk_reset_outputs("reset_values");
    RST = 1'b0;

    w = '{8'hAB};
    run_xfer(9'd5, 1, 0, w);
    w = '{8'h00, 8'hAB, 8'h00, 8'h3C, 8'h00, 8'h05, 8'h3D, 8'h9E, 8'hC3, 8'hD7, 8'h58, 8'h7A, 8'h01, 8'hC2};
    run_xfer(9'd14, 14, 0, w);
    w = {};
    run_xfer(AW'($urandom), 0, 0, w);
    rand_words(w, 3);
    run_xfer(9'd1, 3, 0, w);
    reset_mid_word();
    rand_words(w, 2);
    run_xfer(9'd300, 2, 0, w);
`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
    rand_words(w, 1);
    run_xfer(AW'($urandom), 1, 2, w);
    repeat (3) begin
      rand_words(w, 2);
      run_xfer(AW'($urandom), 2, $urandom_range(0, 3), w);
    end
`endif
    repeat (6) begin
      int len;
      len = $urandom_range(1, 4);
      rand_words(w, len);
      run_xfer(AW'($urandom_range(0, 511)), len, 0, w);
    end

    repeat (3) @(negedge CLK);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 512; i++)
      if (act_mem[i] !== exp_mem[i]) chk("sram_contents", {55'd0, act_mem[i], 1'b0}, {55'd0, exp_mem[i], 1'b0});
    n_checks++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
